// File: rtl/ad_capture_writer.sv
// ad_capture_writer: triggered four-channel AD capture streamed to PSRAM as 4-beat write bursts
// Ports:
//   ad_clk, reset                 clock and synchronous active-high reset
//   ad_a0/a1/b0/b1, ad_strobe     12-bit samples qualified by a one-cycle strobe
//   arm, trig_sel, trig_level,    capture start pulse, trigger channel, rising threshold
//   trig_force                    and forced trigger
//   psram_ready                   low holds the block in reset
//   awaddr/awvalid/awready        burst address channel, set n at n<<3
//   wdata/wvalid/wready/wlast     data channel, beats a0,a1,b0,b1
//   busy, done, overflow, set_cnt status
module ad_capture_writer #(
  parameter int NUM_SETS   = 640,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        ad_clk,
  input  logic        reset,
  input  logic [11:0] ad_a0,
  input  logic [11:0] ad_a1,
  input  logic [11:0] ad_b0,
  input  logic [11:0] ad_b1,
  input  logic        ad_strobe,
  input  logic        arm,
  input  logic [1:0]  trig_sel,
  input  logic [10:0] trig_level,
  input  logic        trig_force,
  input  logic        psram_ready,
  output logic [24:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [17:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  output logic        wlast,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [21:0] set_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [22:0] NS = 23'(NUM_SETS);

  typedef enum logic [1:0] {C_IDLE, C_ARMED, C_CAPTURE, C_DONE} cap_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wr_t;

  cap_t r_cst, w_cst_nxt;
  wr_t  r_wst, w_wst_nxt;

  logic [47:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic [10:0] r_prev;
  logic        r_prev_vld;
  logic [22:0] r_cnt;
  logic [21:0] r_wr_idx;
  logic [1:0]  r_beat;
  logic        r_ovf;

  logic        w_rst, w_empty, w_full, w_cnt_full, w_trig, w_push, w_pop, w_take, w_arm_ok;
  logic [10:0] w_cur;
  logic [47:0] w_head;
  logic [11:0] w_smp;

  assign w_rst      = reset | ~psram_ready;
  assign w_cur      = trig_sel == 2'd0 ? ad_a0[10:0] : trig_sel == 2'd1 ? ad_a1[10:0] :
                      trig_sel == 2'd2 ? ad_b0[10:0] : ad_b1[10:0];
  // prev is only meaningful after the first strobe seen in ARMED
  assign w_trig     = ad_strobe & (trig_force | (r_prev_vld & (r_prev < trig_level) & (w_cur >= trig_level)));
  assign w_cnt_full = r_cnt == NS;
  // a push request counts toward NUM_SETS whether or not the FIFO accepts it
  assign w_push     = ad_strobe & ((r_cst == C_ARMED & w_trig) | (r_cst == C_CAPTURE & ~w_cnt_full));
  assign w_empty    = r_wp == r_rp;
  assign w_full     = (r_wp[AW] != r_rp[AW]) & (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop      = r_wst == W_DATA & wready & r_beat == 2'd3;
  // a same-cycle pop frees the slot for the push
  assign w_take     = w_push & (~w_full | w_pop);
  assign w_arm_ok   = arm & (r_cst == C_IDLE | r_cst == C_DONE);
  assign w_head     = r_mem[r_rp[AW-1:0]];
  assign w_smp      = r_beat == 2'd0 ? w_head[47:36] : r_beat == 2'd1 ? w_head[35:24] :
                      r_beat == 2'd2 ? w_head[23:12] : w_head[11:0];

  always_comb begin
    w_cst_nxt = w_arm_ok ? C_ARMED :
                (r_cst == C_ARMED & w_trig) ? C_CAPTURE :
                (r_cst == C_CAPTURE & w_cnt_full & w_empty & r_wst == W_IDLE) ? C_DONE : r_cst;
    w_wst_nxt = (r_wst == W_IDLE & ~w_empty) ? W_ADDR :
                (r_wst == W_ADDR & awready) ? W_DATA :
                w_pop ? W_IDLE : r_wst;
    awvalid   = r_wst == W_ADDR;
    awaddr    = {r_wr_idx, 3'b000};
    wvalid    = r_wst == W_DATA;
    wlast     = wvalid & r_beat == 2'd3;
    // sample bits [10:3] land on display bits [12:9],[7:4]
    wdata     = wvalid ? {4'b0, w_smp[11], w_smp[10:7], 1'b0, w_smp[6:3], 1'b0, w_smp[2:0]} : '0;
    busy      = r_cst == C_ARMED | r_cst == C_CAPTURE | r_wst != W_IDLE;
    done      = r_cst == C_DONE;
    overflow  = r_ovf;
    set_cnt   = r_wr_idx;
  end

  always_ff @(posedge ad_clk) begin
    if (w_take) r_mem[r_wp[AW-1:0]] <= {ad_a0, ad_a1, ad_b0, ad_b1};
  end

  always_ff @(posedge ad_clk) begin
    if (w_rst) begin
      r_cst      <= C_IDLE;
      r_wst      <= W_IDLE;
      r_wp       <= '0;
      r_rp       <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_cnt      <= '0;
      r_wr_idx   <= '0;
      r_beat     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_cst <= w_cst_nxt;
      r_wst <= w_wst_nxt;
      if (w_take) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
      if (r_cst == C_ARMED & ad_strobe) begin
        r_prev     <= w_cur;
        r_prev_vld <= 1'b1;
      end
      if (w_push) r_cnt <= r_cnt + 23'd1;
      if (w_push & ~w_take) r_ovf <= 1'b1;
      if (w_pop) r_wr_idx <= r_wr_idx + 22'd1;
      if (r_wst == W_DATA & wready) r_beat <= r_beat + 2'd1;
      if (w_arm_ok) begin
        r_prev_vld <= 1'b0;
        r_cnt      <= '0;
        r_wr_idx   <= '0;
        r_ovf      <= 1'b0;
      end
    end
  end
endmodule
